dvp_pixel_rx: RTL and testbench
===============================

// Module: dvp_pixel_rx
// PURPOSE
//  Parametrised DVP camera receiver: next generation of the camera byte-capture front end.
//  Waits for sensor configuration, discards start-up frames, then packs DATA_W-bit bytes into
//  pixels and tags each pixel with coordinates and frame/line markers.
//  Checks frame geometry and flags errors.
//  Sits between the sensor pins (cmos_pclk domain) and the frame-buffer write FIFO.
// PARAMETERS
//  DATA_W         8    sensor bus width (8 or 10)
//  BYTES_PER_PIX  2    bus beats per pixel (1..4); first beat lands in the MSBs
//  SKIP_FRAMES    30   vsync rising edges discarded after cfg_done (0 = none)
//  H_ACTIVE       640  pixels per line
//  V_ACTIVE       480  lines per frame
//  CNT_W          12   width of the pix_x/pix_y counters
// PORTS
//  cmos_pclk  in   1                      pixel clock; sole clock
//  RST        in   1                      synchronous reset, active-high
//  cfg_done   in   1                      sensor SCCB config complete (async level)
//  cmos_vsyn  in   1                      vsync; high = vertical blanking
//  cmos_href  in   1                      line valid
//  cmos_data  in   DATA_W                 sensor data
//  pix_data   out  DATA_W*BYTES_PER_PIX   packed pixel
//  pix_en     out  1                      pix_data/pix_x/pix_y valid (1-cycle strobe)
//  pix_sof    out  1                      with pix_en: first pixel of frame
//  pix_eol    out  1                      with pix_en: last pixel of line
//  pix_x      out  CNT_W                  column of current pixel
//  pix_y      out  CNT_W                  row of current pixel
//  frame_err  out  1                      1-cycle pulse on a geometry error
//  frame_cnt  out  8                      delivered frames; wraps at 255->0
// BEHAVIOUR
//  - Reset: every output is 0 and the FSM enters WAIT_CFG. A reset mid-frame abandons the frame.
//  - cfg_done passes through a 2-flop synchroniser. cmos_vsyn is registered twice:
//    vs_rise = d1&~d2, vs_fall = ~d1&d2.
//  - FSM states:
//      WAIT_CFG -> SKIP when cfg_done_sync=1.
//      SKIP     counts vs_rise; -> WAIT_VS when the count reaches SKIP_FRAMES.
//               With SKIP_FRAMES=0, go straight to WAIT_VS.
//      WAIT_VS  -> ACTIVE on vs_fall.
//      ACTIVE   -> WAIT_VS on vs_rise; frame_cnt++ and geometry check on that same edge.
//    From any state, cfg_done_sync=0 returns the FSM to WAIT_CFG.
//  - Capture qualifier: state==ACTIVE & cmos_href & ~cmos_vsyn.
//    A beat counter advances on each qualified cycle. Beat 0 goes to the MSBs of the shift register.
//  - On beat BYTES_PER_PIX-1, pix_en=1 on the next edge (latency 1 cycle after the last beat).
//    pix_x/pix_y are registered alongside pix_data.
//  - The beat counter clears whenever href=0. A partial pixel at href fall is dropped and pulses frame_err.
//  - pix_x increments per pixel and clears on href fall. pix_y increments on href fall if the line
//    produced at least 1 pixel; pix_y clears on vs_fall.
//  - Pixels with x>=H_ACTIVE are dropped: no pix_en. frame_err pulses once per such line.
//  - pix_eol=1 with the pixel at x==H_ACTIVE-1. A line ending with x!=H_ACTIVE pulses frame_err.
//  - pix_sof=1 with pixel (0,0) only.
//  - vs_rise in ACTIVE with line count != V_ACTIVE pulses frame_err.
//    Lines beyond V_ACTIVE are dropped.
//  - Simultaneous partial-pixel and line-length errors produce a single frame_err pulse.
// CONFIGURATION
//  CAM_CROP_EN defined:
//    Adds inputs crop_x0, crop_y0, crop_w, crop_h (CNT_W each), sampled on vs_fall only.
//    pix_en fires only inside the window. pix_x/pix_y are window-relative.
//    pix_sof/pix_eol refer to the window corners/edge.
//    Geometry checks still use H_ACTIVE/V_ACTIVE. A window exceeding the frame is clipped.
//  CAM_CROP_EN undefined:
//    No crop ports; full H_ACTIVE x V_ACTIVE frame delivered.
// STRUCTURE
//  - Package cam_rx_pkg: FSM state enum (WAIT_CFG, SKIP, WAIT_VS, ACTIVE) and default geometry constants.
//  - Sub-module dvp_byte_packer: beat counter + shift register.
//    Params DATA_W, BYTES_PER_PIX; outputs packed word, done strobe, partial flag.
//  - Top level: sync, FSM, counters, checks, crop.
// TESTING
//  1. cfg_done=1, SKIP_FRAMES=2, 3 frames of 4x2 pixels
//     -> no pix_en in frames 1-2; frame 3 gives 8 pix_en, frame_cnt=1.
//  2. BYTES_PER_PIX=2, beats A5,3C
//     -> pix_data=16'hA53C one cycle after the 3C beat; first pixel has pix_sof=1, x=y=0.
//  3. href drops after 3 beats of a line (partial pixel)
//     -> 1 pix_en, 1 frame_err pulse, next line starts at x=0.
//  4. Line of H_ACTIVE+2 pixels
//     -> pix_eol on x=H_ACTIVE-1, 2 extra pixels dropped, 1 frame_err.
//  5. RST asserted mid-line, then released
//     -> all outputs 0; capture resumes only after skip frames and the next vs_fall.
//  6. CAM_CROP_EN, window (2,1,2,1) on a 4x2 frame
//     -> exactly 2 pix_en: (0,0) with sof, (1,0) with eol.

Source files
------------

// File: rtl/cam_rx_pkg.sv
// cam_rx_pkg: shared FSM state encoding and default geometry for the DVP camera receiver.
//   state_t / WAIT_CFG, SKIP, WAIT_VS, ACTIVE : receiver FSM states
//   DEF_* : default parameter values for dvp_pixel_rx
package cam_rx_pkg;
   typedef logic [1:0] state_t;
   localparam state_t WAIT_CFG = 2'd0;
   localparam state_t SKIP     = 2'd1;
   localparam state_t WAIT_VS  = 2'd2;
   localparam state_t ACTIVE   = 2'd3;
   localparam int DEF_DATA_W        = 8;
   localparam int DEF_BYTES_PER_PIX = 2;
   localparam int DEF_SKIP_FRAMES   = 30;
   localparam int DEF_H_ACTIVE      = 640;
   localparam int DEF_V_ACTIVE      = 480;
   localparam int DEF_CNT_W         = 12;
endpackage

// File: rtl/dvp_byte_packer.sv
// dvp_byte_packer: gathers BYTES_PER_PIX bus beats into one pixel word, first beat in the MSBs.
//   clk, rst  : clock, synchronous active-high reset
//   en        : beat qualifier (one beat per cycle)
//   clr       : restart the beat count (line ended)
//   data      : sensor beat
//   word      : packed pixel, valid while done=1 (includes the current beat)
//   done      : current beat completes a pixel
//   partial   : some beats of an unfinished pixel are held
module dvp_byte_packer #(
   parameter int DATA_W        = 8,
   parameter int BYTES_PER_PIX = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            clr,
   input  logic [DATA_W-1:0]               data,
   output logic [DATA_W*BYTES_PER_PIX-1:0] word,
   output logic                            done,
   output logic                            partial
);
   localparam logic [1:0] LAST = 2'(BYTES_PER_PIX - 1);
   logic [1:0] beat;
   assign done    = en & (beat == LAST);
   assign partial = beat != 2'd0;
   always_ff @(posedge clk) begin
      if (rst || clr) beat <= 2'd0;
      else if (en) beat <= done ? 2'd0 : beat + 2'd1;
   end
   generate
      if (BYTES_PER_PIX == 1) begin : g_one
         assign word = data;
      end else begin : g_shift
         localparam int PREV_W = (BYTES_PER_PIX - 1) * DATA_W;
         logic [PREV_W-1:0] sreg;
         // keep only the most recent BYTES_PER_PIX-1 beats; the current beat completes the word
         always_ff @(posedge clk) begin
            if (rst) sreg <= '0;
            else if (en) sreg <= PREV_W'({sreg, data});
         end
         assign word = {sreg, data};
      end
   endgenerate
endmodule

// File: rtl/dvp_pixel_rx.sv
// dvp_pixel_rx: DVP camera receiver; waits for sensor config, skips start-up frames, packs
// beats into pixels, tags coordinates/markers and checks frame geometry.
// Optional crop window enabled by macro CAM_CROP_EN.
//   cmos_pclk, RST        : pixel clock, synchronous active-high reset
//   cfg_done              : sensor configuration complete (asynchronous level)
//   cmos_vsyn, cmos_href  : vsync (high = blanking), line valid
//   cmos_data             : sensor bus
//   crop_x0/y0/w/h        : crop window, sampled at vsync fall (CAM_CROP_EN only)
//   pix_data, pix_en      : packed pixel and its 1-cycle valid strobe
//   pix_sof, pix_eol      : first pixel of frame, last pixel of line (with pix_en)
//   pix_x, pix_y          : pixel coordinates
//   frame_err             : 1-cycle pulse on a geometry error
//   frame_cnt             : delivered frames, wrapping
module dvp_pixel_rx import cam_rx_pkg::*; #(
   parameter int DATA_W        = DEF_DATA_W,
   parameter int BYTES_PER_PIX = DEF_BYTES_PER_PIX,
   parameter int SKIP_FRAMES   = DEF_SKIP_FRAMES,
   parameter int H_ACTIVE      = DEF_H_ACTIVE,
   parameter int V_ACTIVE      = DEF_V_ACTIVE,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic                            cmos_pclk,
   input  logic                            RST,
   input  logic                            cfg_done,
   input  logic                            cmos_vsyn,
   input  logic                            cmos_href,
   input  logic [DATA_W-1:0]               cmos_data,
`ifdef CAM_CROP_EN
   input  logic [CNT_W-1:0]                crop_x0,
   input  logic [CNT_W-1:0]                crop_y0,
   input  logic [CNT_W-1:0]                crop_w,
   input  logic [CNT_W-1:0]                crop_h,
`endif
   output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data,
   output logic                            pix_en,
   output logic                            pix_sof,
   output logic                            pix_eol,
   output logic [CNT_W-1:0]                pix_x,
   output logic [CNT_W-1:0]                pix_y,
   output logic                            frame_err,
   output logic [7:0]                      frame_cnt
);
   localparam logic [CNT_W-1:0] H_N    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_N    = CNT_W'(V_ACTIVE);
   localparam logic [7:0]       SKIP_N = 8'(SKIP_FRAMES);
   logic cfg_s1, cfg_sync, vs_d1, vs_d2, href_d;
   state_t state;
   logic [7:0] skip_cnt;
   logic [CNT_W-1:0] x_cnt, y_cnt, rel_x, rel_y;
   logic [DATA_W*BYTES_PER_PIX-1:0] word;
   logic done, partial, win, sof, eol;
   wire vs_rise   = vs_d1 & ~vs_d2;
   wire vs_fall   = ~vs_d1 & vs_d2;
   wire cap       = (state == ACTIVE) & cmos_href & ~cmos_vsyn;
   wire line_end  = (state == ACTIVE) & href_d & ~cmos_href;
   wire frame_end = (state == ACTIVE) & vs_rise;
   wire in_frame  = (x_cnt < H_N) & (y_cnt < V_N);

   dvp_byte_packer #(.DATA_W(DATA_W), .BYTES_PER_PIX(BYTES_PER_PIX)) u_packer (
      .clk(cmos_pclk), .rst(RST), .en(cap), .clr(~cmos_href), .data(cmos_data),
      .word(word), .done(done), .partial(partial)
   );

`ifdef CAM_CROP_EN
   localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
   logic [CNT_W-1:0] cx0, cy0, cw, ch;
   logic [CNT_W:0] xe_raw, ye_raw, xe, ye;
   // window end coordinates (exclusive), clipped to the active frame
   always_comb begin
      xe_raw = {1'b0, cx0} + {1'b0, cw};
      ye_raw = {1'b0, cy0} + {1'b0, ch};
      xe     = (xe_raw > {1'b0, H_N}) ? {1'b0, H_N} : xe_raw;
      ye     = (ye_raw > {1'b0, V_N}) ? {1'b0, V_N} : ye_raw;
      win    = in_frame & (x_cnt >= cx0) & ({1'b0, x_cnt} < xe) & (y_cnt >= cy0) & ({1'b0, y_cnt} < ye);
      rel_x  = x_cnt - cx0;
      rel_y  = y_cnt - cy0;
      sof    = (x_cnt == cx0) & (y_cnt == cy0);
      eol    = ({1'b0, x_cnt} + ONE) == xe;
   end
   always_ff @(posedge cmos_pclk) begin
      if (RST) begin
         cx0 <= '0;
         cy0 <= '0;
         cw  <= '0;
         ch  <= '0;
      end else if (vs_fall) begin
         cx0 <= crop_x0;
         cy0 <= crop_y0;
         cw  <= crop_w;
         ch  <= crop_h;
      end
   end
`else
   always_comb begin
      win   = in_frame;
      rel_x = x_cnt;
      rel_y = y_cnt;
      sof   = (x_cnt == '0) & (y_cnt == '0);
      eol   = x_cnt == H_N - CNT_W'(1);
   end
`endif

   always_ff @(posedge cmos_pclk) begin
      if (RST) begin
         cfg_s1   <= 1'b0;
         cfg_sync <= 1'b0;
         vs_d1    <= 1'b0;
         vs_d2    <= 1'b0;
         href_d   <= 1'b0;
      end else begin
         cfg_s1   <= cfg_done;
         cfg_sync <= cfg_s1;
         vs_d1    <= cmos_vsyn;
         vs_d2    <= vs_d1;
         href_d   <= cmos_href;
      end
   end

   always_ff @(posedge cmos_pclk) begin
      if (RST || !cfg_sync) begin
         state    <= WAIT_CFG;
         skip_cnt <= 8'd0;
      end else begin
         case (state)
            WAIT_CFG: state <= SKIP;
            SKIP:
               if (skip_cnt == SKIP_N) state <= WAIT_VS;
               else if (vs_rise) skip_cnt <= skip_cnt + 8'd1;
            WAIT_VS: if (vs_fall) state <= ACTIVE;
            default: if (vs_rise) state <= WAIT_VS;
         endcase
      end
   end

   always_ff @(posedge cmos_pclk) begin
      if (RST) begin
         pix_data  <= '0;
         pix_en    <= 1'b0;
         pix_sof   <= 1'b0;
         pix_eol   <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         frame_err <= 1'b0;
         frame_cnt <= 8'd0;
         x_cnt     <= '0;
         y_cnt     <= '0;
      end else begin
         pix_en  <= done & win;
         pix_sof <= done & win & sof;
         pix_eol <= done & win & eol;
         if (done && win) begin
            pix_data <= word;
            pix_x    <= rel_x;
            pix_y    <= rel_y;
         end
         x_cnt <= !cmos_href ? '0 : done ? x_cnt + CNT_W'(1) : x_cnt;
         y_cnt <= vs_fall ? '0 : (line_end && x_cnt != '0) ? y_cnt + CNT_W'(1) : y_cnt;
         // partial pixel and wrong line length share one pulse; over-long lines are caught here too
         frame_err <= (line_end & (partial | (x_cnt != H_N))) | (frame_end & (y_cnt != V_N));
         if (frame_end) frame_cnt <= frame_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_dvp_pixel_rx.sv
// tb_dvp_pixel_rx: directed bench for dvp_pixel_rx on a 4x2 frame, 2 beats/pixel, 2 skip frames.
module tb_dvp_pixel_rx;
   logic clk = 1'b0, rst = 1'b1, cfg_done = 1'b1, vsyn = 1'b1, href = 1'b0;
   logic [7:0] data = 8'd0;
   logic [15:0] pix_data;
   logic pix_en, pix_sof, pix_eol, frame_err;
   logic [11:0] pix_x, pix_y;
   logic [7:0] frame_cnt;
`ifdef CAM_CROP_EN
   logic [11:0] crop_x0 = 12'd0, crop_y0 = 12'd0, crop_w = 12'd4, crop_h = 12'd2;
`endif
   int errors = 0, checks = 0;
   int en_cnt = 0, err_cnt = 0, sof_cnt = 0, eol_cnt = 0, bad_x = 0;
   int m_en, m_err, m_sof, m_eol;
   logic [15:0] rec_d [64];
   int rec_x [64], rec_y [64];
   logic rec_sof [64], rec_eol [64];

   always #5 clk = ~clk;

   dvp_pixel_rx #(.DATA_W(8), .BYTES_PER_PIX(2), .SKIP_FRAMES(2), .H_ACTIVE(4), .V_ACTIVE(2), .CNT_W(12)) dut (
      .cmos_pclk(clk), .RST(rst), .cfg_done(cfg_done), .cmos_vsyn(vsyn), .cmos_href(href), .cmos_data(data),
`ifdef CAM_CROP_EN
      .crop_x0(crop_x0), .crop_y0(crop_y0), .crop_w(crop_w), .crop_h(crop_h),
`endif
      .pix_data(pix_data), .pix_en(pix_en), .pix_sof(pix_sof), .pix_eol(pix_eol),
      .pix_x(pix_x), .pix_y(pix_y), .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   always @(posedge clk) begin
      #1;
      if (pix_en) begin
         rec_d[en_cnt % 64]   = pix_data;
         rec_x[en_cnt % 64]   = int'(pix_x);
         rec_y[en_cnt % 64]   = int'(pix_y);
         rec_sof[en_cnt % 64] = pix_sof;
         rec_eol[en_cnt % 64] = pix_eol;
         en_cnt++;
         if (pix_sof) sof_cnt++;
         if (pix_eol) eol_cnt++;
         if (pix_x >= 12'd4) bad_x++;
      end
      if (frame_err) err_cnt++;
   end

   task automatic mark();
      m_en = en_cnt; m_err = err_cnt; m_sof = sof_cnt; m_eol = eol_cnt;
   endtask

   task automatic drive(input logic h, input logic [7:0] d);
      href = h; data = d;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'd0);
   endtask

   task automatic line(input int nb, input logic [7:0] base);
      for (int i = 0; i < nb; i++) drive(1'b1, base + 8'(i));
      idle(3);
   endtask

   task automatic frame(input int nl, input int nb, input logic [7:0] base);
      vsyn = 1'b0;
      idle(5);
      for (int l = 0; l < nl; l++) line(nb, base + 8'(16 * l));
      vsyn = 1'b1;
      idle(6);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(4);
      checks++; if ({pix_en, pix_sof, pix_eol, frame_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {pix_en, pix_sof, pix_eol, frame_err}); end
      checks++; if ({pix_data, pix_x, pix_y, frame_cnt} !== 48'd0) begin errors++; $display("FAIL reset_values: got %h want 0", {pix_data, pix_x, pix_y, frame_cnt}); end
      rst = 1'b0;
      idle(6);
   endtask

   task automatic test_skip();
      mark();
      frame(2, 8, 8'h10);
      frame(2, 8, 8'h10);
      checks++; if (en_cnt - m_en !== 0) begin errors++; $display("FAIL skip_no_pix: got %0d want 0", en_cnt - m_en); end
      checks++; if (err_cnt - m_err !== 0) begin errors++; $display("FAIL skip_no_err: got %0d want 0", err_cnt - m_err); end
      mark();
      frame(2, 8, 8'h10);
      checks++; if (en_cnt - m_en !== 8) begin errors++; $display("FAIL skip_frame3_pix: got %0d want 8", en_cnt - m_en); end
      checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL skip_frame_cnt: got %0d want 1", frame_cnt); end
      checks++; if (err_cnt - m_err !== 0) begin errors++; $display("FAIL skip_frame3_err: got %0d want 0", err_cnt - m_err); end
      checks++; if ({sof_cnt - m_sof, eol_cnt - m_eol} !== {32'd1, 32'd2}) begin errors++; $display("FAIL skip_markers: got sof=%0d eol=%0d want 1 2", sof_cnt - m_sof, eol_cnt - m_eol); end
      checks++; if ({rec_d[m_en % 64], rec_sof[m_en % 64]} !== {16'h1011, 1'b1} || rec_x[m_en % 64] != 0 || rec_y[m_en % 64] != 0) begin errors++; $display("FAIL skip_first_pix: got %h sof=%b (%0d,%0d) want 1011 sof=1 (0,0)", rec_d[m_en % 64], rec_sof[m_en % 64], rec_x[m_en % 64], rec_y[m_en % 64]); end
      checks++; if ({rec_d[(m_en + 7) % 64], rec_eol[(m_en + 7) % 64]} !== {16'h2627, 1'b1} || rec_x[(m_en + 7) % 64] != 3 || rec_y[(m_en + 7) % 64] != 1) begin errors++; $display("FAIL skip_last_pix: got %h eol=%b (%0d,%0d) want 2627 eol=1 (3,1)", rec_d[(m_en + 7) % 64], rec_eol[(m_en + 7) % 64], rec_x[(m_en + 7) % 64], rec_y[(m_en + 7) % 64]); end
   endtask

   task automatic test_pack();
      vsyn = 1'b0;
      idle(5);
      mark();
      drive(1'b1, 8'hA5);
      checks++; if (pix_en !== 1'b0) begin errors++; $display("FAIL pack_early: got pix_en=%b want 0", pix_en); end
      drive(1'b1, 8'h3C);
      checks++; if ({pix_en, pix_sof, pix_data} !== {1'b1, 1'b1, 16'hA53C}) begin errors++; $display("FAIL pack_word: got en=%b sof=%b data=%h want en=1 sof=1 data=a53c", pix_en, pix_sof, pix_data); end
      checks++; if ({pix_x, pix_y} !== 24'd0) begin errors++; $display("FAIL pack_xy: got (%0d,%0d) want (0,0)", pix_x, pix_y); end
      for (int i = 2; i < 8; i++) drive(1'b1, 8'(i));
      idle(3);
      line(8, 8'h40);
      vsyn = 1'b1;
      idle(6);
      checks++; if ({en_cnt - m_en, err_cnt - m_err} !== {32'd8, 32'd0}) begin errors++; $display("FAIL pack_frame: got pix=%0d err=%0d want 8 0", en_cnt - m_en, err_cnt - m_err); end
      checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL pack_frame_cnt: got %0d want 2", frame_cnt); end
   endtask

   task automatic test_partial();
      mark();
      vsyn = 1'b0;
      idle(5);
      line(3, 8'h50);
      line(8, 8'h60);
      vsyn = 1'b1;
      idle(6);
      checks++; if (en_cnt - m_en !== 5) begin errors++; $display("FAIL partial_pix: got %0d want 5", en_cnt - m_en); end
      checks++; if (err_cnt - m_err !== 1) begin errors++; $display("FAIL partial_err: got %0d want 1", err_cnt - m_err); end
      checks++; if (rec_d[(m_en + 1) % 64] !== 16'h6061 || rec_x[(m_en + 1) % 64] != 0 || rec_y[(m_en + 1) % 64] != 1) begin errors++; $display("FAIL partial_next_line: got %h (%0d,%0d) want 6061 (0,1)", rec_d[(m_en + 1) % 64], rec_x[(m_en + 1) % 64], rec_y[(m_en + 1) % 64]); end
      checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL partial_frame_cnt: got %0d want 3", frame_cnt); end
   endtask

   task automatic test_long_line();
      mark();
      vsyn = 1'b0;
      idle(5);
      line(12, 8'h70);
      line(8, 8'h80);
      vsyn = 1'b1;
      idle(6);
      checks++; if ({en_cnt - m_en, err_cnt - m_err} !== {32'd8, 32'd1}) begin errors++; $display("FAIL long_counts: got pix=%0d err=%0d want 8 1", en_cnt - m_en, err_cnt - m_err); end
      checks++; if (rec_eol[(m_en + 3) % 64] !== 1'b1 || rec_x[(m_en + 3) % 64] != 3 || eol_cnt - m_eol != 2) begin errors++; $display("FAIL long_eol: got eol=%b x=%0d n=%0d want eol=1 x=3 n=2", rec_eol[(m_en + 3) % 64], rec_x[(m_en + 3) % 64], eol_cnt - m_eol); end
      checks++; if (rec_d[(m_en + 4) % 64] !== 16'h8081 || rec_x[(m_en + 4) % 64] != 0 || rec_y[(m_en + 4) % 64] != 1) begin errors++; $display("FAIL long_next_line: got %h (%0d,%0d) want 8081 (0,1)", rec_d[(m_en + 4) % 64], rec_x[(m_en + 4) % 64], rec_y[(m_en + 4) % 64]); end
      checks++; if (bad_x !== 0) begin errors++; $display("FAIL long_dropped: got %0d pixels with x>=4 want 0", bad_x); end
   endtask

   task automatic test_frame_lines();
      mark();
      frame(1, 8, 8'h90);
      checks++; if ({en_cnt - m_en, err_cnt - m_err} !== {32'd4, 32'd1}) begin errors++; $display("FAIL short_frame: got pix=%0d err=%0d want 4 1", en_cnt - m_en, err_cnt - m_err); end
      mark();
      frame(3, 8, 8'hA0);
      checks++; if ({en_cnt - m_en, err_cnt - m_err} !== {32'd8, 32'd1}) begin errors++; $display("FAIL tall_frame: got pix=%0d err=%0d want 8 1", en_cnt - m_en, err_cnt - m_err); end
      checks++; if (frame_cnt !== 8'd6) begin errors++; $display("FAIL lines_frame_cnt: got %0d want 6", frame_cnt); end
   endtask

   task automatic test_reset_mid_line();
      vsyn = 1'b0;
      idle(5);
      drive(1'b1, 8'h01);
      drive(1'b1, 8'h02);
      drive(1'b1, 8'h03);
      rst = 1'b1;
      drive(1'b1, 8'h04);
      drive(1'b1, 8'h05);
      checks++; if ({pix_en, pix_sof, pix_eol, frame_err} !== 4'b0) begin errors++; $display("FAIL midrst_flags: got %b want 0000", {pix_en, pix_sof, pix_eol, frame_err}); end
      checks++; if ({pix_data, pix_x, pix_y, frame_cnt} !== 48'd0) begin errors++; $display("FAIL midrst_values: got %h want 0", {pix_data, pix_x, pix_y, frame_cnt}); end
      rst = 1'b0;
      idle(4);
      mark();
      vsyn = 1'b1;
      idle(6);
      frame(2, 8, 8'h10);
      checks++; if ({en_cnt - m_en, err_cnt - m_err} !== {32'd0, 32'd0}) begin errors++; $display("FAIL midrst_skip: got pix=%0d err=%0d want 0 0", en_cnt - m_en, err_cnt - m_err); end
      frame(2, 8, 8'hB0);
      checks++; if ({en_cnt - m_en, err_cnt - m_err} !== {32'd8, 32'd0}) begin errors++; $display("FAIL midrst_resume: got pix=%0d err=%0d want 8 0", en_cnt - m_en, err_cnt - m_err); end
      checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL midrst_frame_cnt: got %0d want 1", frame_cnt); end
   endtask

`ifdef CAM_CROP_EN
   task automatic test_crop();
      crop_x0 = 12'd2; crop_y0 = 12'd1; crop_w = 12'd2; crop_h = 12'd1;
      mark();
      frame(2, 8, 8'hD0);
      checks++; if (en_cnt - m_en !== 2) begin errors++; $display("FAIL crop_pix: got %0d want 2", en_cnt - m_en); end
      checks++; if ({rec_d[m_en % 64], rec_sof[m_en % 64], rec_eol[m_en % 64]} !== {16'hE4E5, 1'b1, 1'b0} || rec_x[m_en % 64] != 0 || rec_y[m_en % 64] != 0) begin errors++; $display("FAIL crop_first: got %h sof=%b eol=%b (%0d,%0d) want e4e5 1 0 (0,0)", rec_d[m_en % 64], rec_sof[m_en % 64], rec_eol[m_en % 64], rec_x[m_en % 64], rec_y[m_en % 64]); end
      checks++; if ({rec_d[(m_en + 1) % 64], rec_sof[(m_en + 1) % 64], rec_eol[(m_en + 1) % 64]} !== {16'hE6E7, 1'b0, 1'b1} || rec_x[(m_en + 1) % 64] != 1 || rec_y[(m_en + 1) % 64] != 0) begin errors++; $display("FAIL crop_second: got %h sof=%b eol=%b (%0d,%0d) want e6e7 0 1 (1,0)", rec_d[(m_en + 1) % 64], rec_sof[(m_en + 1) % 64], rec_eol[(m_en + 1) % 64], rec_x[(m_en + 1) % 64], rec_y[(m_en + 1) % 64]); end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_skip();
      test_pack();
      test_partial();
      test_long_line();
      test_frame_lines();
      test_reset_mid_line();
`ifdef CAM_CROP_EN
      test_crop();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
